// File: rtl/alu_pkg.sv
// Shared widths and function codes for the C-Trino ALU, used by the decoder, the ALU and the bench.
package alu_pkg;

   localparam int unsigned ALU_WIDTH      = 32;
   localparam int unsigned ALU_FUNC_WIDTH = 5;

   typedef enum logic [ALU_FUNC_WIDTH-1:0] {
      _ALU_ADD   = 5'd0,
      _ALU_SUB   = 5'd1,
      _ALU_INC   = 5'd2,
      _ALU_DEC   = 5'd3,
      _ALU_AND   = 5'd4,
      _ALU_OR    = 5'd5,
      _ALU_XOR   = 5'd6,
      _ALU_NOT   = 5'd7,
      _ALU_SHL   = 5'd8,
      _ALU_SHR   = 5'd9,
      _ALU_SRA   = 5'd10,
      _ALU_ROL   = 5'd11,
      _ALU_ROR   = 5'd12,
      _ALU_SLT   = 5'd13,
      _ALU_SLTU  = 5'd14,
      _ALU_EQ    = 5'd15,
      _ALU_PASSA = 5'd16,
      _ALU_PASSB = 5'd17,
      _ALU_ZERO  = 5'd18,
      _ALU_ONE   = 5'd19,
      _ALU_NOP   = 5'd20,
      _ALU_MAX   = 5'd21
   } alu_func_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational shift/rotate unit for the ALU; also reports the last bit shifted out.
module alu_shifter
   import alu_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic [Width-1:0]         a_i,
   input  logic [$clog2(Width)-1:0] n_i,
   input  alu_func_e                op_i,
   output logic [Width-1:0]         s_o,
   output logic                     co_o
);

   // One guard bit on the exit side captures the last bit shifted out (0 when n=0).
   logic [Width:0]   shl_t;
   logic [Width:0]   shr_t;
   logic [Width:0]   sra_t;
   logic [Width-1:0] rol_t;
   logic [Width-1:0] ror_t;

   always_comb begin
      shl_t = {1'b0, a_i} << n_i;
      shr_t = {a_i, 1'b0} >> n_i;
      sra_t = $signed({a_i, 1'b0}) >>> n_i;
      // A shift by the full width yields 0, so n=0 degenerates cleanly to a.
      rol_t = (a_i << n_i) | (a_i >> (Width - n_i));
      ror_t = (a_i >> n_i) | (a_i << (Width - n_i));

      s_o  = '0;
      co_o = 1'b0;
      case (op_i)
         _ALU_SHL: begin
            s_o  = shl_t[Width-1:0];
            co_o = shl_t[Width];
         end
         _ALU_SHR: begin
            s_o  = shr_t[Width:1];
            co_o = shr_t[0];
         end
         _ALU_SRA: begin
            s_o  = sra_t[Width:1];
            co_o = sra_t[0];
         end
         _ALU_ROL: s_o = rol_t;
         _ALU_ROR: s_o = ror_t;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Registered W-bit integer ALU: one operation per clock selected by f, result and carry after 1 cycle.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned ALU_WIDTH      = alu_pkg::ALU_WIDTH,
   parameter int unsigned ALU_FUNC_WIDTH = alu_pkg::ALU_FUNC_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ALU_WIDTH-1:0]      a,
   input  logic [ALU_WIDTH-1:0]      b,
   input  logic                      ci,
   input  logic [ALU_FUNC_WIDTH-1:0] f,
   output logic [ALU_WIDTH-1:0]      s,
   output logic                      co
);

   localparam int unsigned ShW = $clog2(ALU_WIDTH);

   alu_func_e            func;
   logic [ALU_WIDTH-1:0] add_b;
   logic                 add_c;
   logic [ALU_WIDTH:0]   sum;
   logic [ALU_WIDTH-1:0] sh_s;
   logic                 sh_co;
   logic                 lt_s;
   logic                 lt_u;
   logic                 eq;
   logic [ALU_WIDTH-1:0] s_d, s_q;
   logic                 co_d, co_q;

   assign func = alu_func_e'(f);

   // ADD/SUB/INC/DEC share one adder; only the B operand and carry-in differ.
   always_comb begin
      add_b = b;
      add_c = ci;
      case (func)
         _ALU_SUB: add_b = ~b;
         _ALU_INC: begin
            add_b = '0;
            add_c = 1'b1;
         end
         _ALU_DEC: begin
            add_b = '1;
            add_c = 1'b0;
         end
         default: ;
      endcase
   end

   assign sum  = {1'b0, a} + {1'b0, add_b} + {{ALU_WIDTH{1'b0}}, add_c};
   assign lt_s = $signed(a) < $signed(b);
   assign lt_u = a < b;
   assign eq   = a == b;

   alu_shifter #(
      .Width (ALU_WIDTH)
   ) u_shifter (
      .a_i  (a),
      .n_i  (b[ShW-1:0]),
      .op_i (func),
      .s_o  (sh_s),
      .co_o (sh_co)
   );

   always_comb begin
      s_d  = '0;
      co_d = 1'b0;
      case (func)
         _ALU_ADD, _ALU_SUB, _ALU_INC, _ALU_DEC: begin
            s_d  = sum[ALU_WIDTH-1:0];
            co_d = sum[ALU_WIDTH];
         end
         _ALU_AND:   s_d = a & b;
         _ALU_OR:    s_d = a | b;
         _ALU_XOR:   s_d = a ^ b;
         _ALU_NOT:   s_d = ~a;
         _ALU_SHL, _ALU_SHR, _ALU_SRA, _ALU_ROL, _ALU_ROR: begin
            s_d  = sh_s;
            co_d = sh_co;
         end
         _ALU_SLT: begin
            s_d  = {{(ALU_WIDTH-1){1'b0}}, lt_s};
            co_d = lt_s;
         end
         _ALU_SLTU: begin
            s_d  = {{(ALU_WIDTH-1){1'b0}}, lt_u};
            co_d = lt_u;
         end
         _ALU_EQ: begin
            s_d  = {{(ALU_WIDTH-1){1'b0}}, eq};
            co_d = eq;
         end
         _ALU_PASSA: s_d = a;
         _ALU_PASSB: s_d = b;
         _ALU_ZERO:  s_d = '0;
         _ALU_ONE:   s_d = {{(ALU_WIDTH-1){1'b0}}, 1'b1};
         _ALU_NOP: begin
            s_d  = s_q;
            co_d = co_q;
         end
         _ALU_MAX:   s_d = '1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q  <= '0;
         co_q <= 1'b0;
      end else begin
         s_q  <= s_d;
         co_q <= co_d;
      end
   end

   assign s  = s_q;
   assign co = co_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU at W=32.
module tb_alu;
   import alu_pkg::*;

   typedef struct {
      logic [4:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic        ci;
      logic [31:0] s;
      logic        co;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] a;
   logic [31:0] b;
   logic        ci;
   logic [4:0]  f;
   logic [31:0] s;
   logic        co;

   int total;
   int bad;

   alu #(
      .ALU_WIDTH      (32),
      .ALU_FUNC_WIDTH (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .ci    (ci),
      .f     (f),
      .s     (s),
      .co    (co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      f     = _ALU_ONE;
      a     = 32'h0;
      b     = 32'h0;
      ci    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (s !== 32'h0 || co !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: s=%h co=%b want s=0 co=0", s, co);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (s !== 32'h0 || co !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_hold: s=%h co=%b want s=0 co=0", s, co);
      end
      @(posedge clk);
      #1;
      total++;
      if (s !== 32'h1) begin
         bad++;
         $display("FAIL first_edge_one: s=%h want 00000001", s);
      end
      // Reset mid-cycle must clear the outputs without waiting for a clock edge.
      @(negedge clk);
      f  = _ALU_MAX;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (s !== 32'h0 || co !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: s=%h co=%b want s=0 co=0", s, co);
      end
      @(posedge clk);
      #1;
      total++;
      if (s !== 32'h0 || co !== 1'b0) begin
         bad++;
         $display("FAIL reset_held: s=%h co=%b want s=0 co=0", s, co);
      end
      @(negedge clk);
      rst_n = 1'b1;
      f     = _ALU_ONE;
   endtask

   task automatic test_add();
      vec_t v[3];
      v = '{
         '{5'd0, 32'h1, 32'h2, 1'b1, 32'h4, 1'b0},
         '{5'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1},
         '{5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0}
      };
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         f  = v[i].f;
         a  = v[i].a;
         b  = v[i].b;
         ci = v[i].ci;
         @(posedge clk);
         #1;
         total++;
         if (s !== v[i].s || co !== v[i].co) begin
            bad++;
            $display("FAIL add[%0d]: s=%h co=%b want s=%h co=%b", i, s, co, v[i].s, v[i].co);
         end
      end
   endtask

   task automatic test_consts();
      // ADD overflow leaves co=1 so that the NOP hold of co is observable.
      vec_t v[6];
      v = '{
         '{5'd21, 32'h2, 32'h2, 1'b1, 32'hFFFF_FFFF, 1'b0},
         '{5'd19, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h1, 1'b0},
         '{5'd20, 32'h5, 32'h6, 1'b1, 32'h1, 1'b0},
         '{5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1},
         '{5'd20, 32'h9, 32'h9, 1'b0, 32'h0, 1'b1},
         '{5'd18, 32'h9, 32'h9, 1'b1, 32'h0, 1'b0}
      };
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         f  = v[i].f;
         a  = v[i].a;
         b  = v[i].b;
         ci = v[i].ci;
         @(posedge clk);
         #1;
         total++;
         if (s !== v[i].s || co !== v[i].co) begin
            bad++;
            $display("FAIL const[%0d]: s=%h co=%b want s=%h co=%b", i, s, co, v[i].s, v[i].co);
         end
      end
   endtask

   task automatic test_sub();
      vec_t v[6];
      v = '{
         '{5'd1, 32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0},
         '{5'd1, 32'h7, 32'h5, 1'b1, 32'h2, 1'b1},
         '{5'd2, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1},
         '{5'd2, 32'h1, 32'h0, 1'b1, 32'h2, 1'b0},
         '{5'd3, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0},
         '{5'd3, 32'h5, 32'h0, 1'b1, 32'h4, 1'b1}
      };
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         f  = v[i].f;
         a  = v[i].a;
         b  = v[i].b;
         ci = v[i].ci;
         @(posedge clk);
         #1;
         total++;
         if (s !== v[i].s || co !== v[i].co) begin
            bad++;
            $display("FAIL sub[%0d]: s=%h co=%b want s=%h co=%b", i, s, co, v[i].s, v[i].co);
         end
      end
   endtask

   task automatic test_shift();
      // b=32 checks that only b[4:0] is used as the shift amount.
      vec_t v[7];
      v = '{
         '{5'd8, 32'h8000_0001, 32'h1, 1'b0, 32'h2, 1'b1},
         '{5'd10, 32'h8000_0000, 32'h4, 1'b0, 32'hF800_0000, 1'b0},
         '{5'd12, 32'h1, 32'h1, 1'b0, 32'h8000_0000, 1'b0},
         '{5'd9, 32'h3, 32'h1, 1'b1, 32'h1, 1'b1},
         '{5'd9, 32'h10, 32'h5, 1'b0, 32'h0, 1'b1},
         '{5'd8, 32'h1234, 32'h20, 1'b1, 32'h1234, 1'b0},
         '{5'd11, 32'h8000_0001, 32'h4, 1'b0, 32'h18, 1'b0}
      };
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         f  = v[i].f;
         a  = v[i].a;
         b  = v[i].b;
         ci = v[i].ci;
         @(posedge clk);
         #1;
         total++;
         if (s !== v[i].s || co !== v[i].co) begin
            bad++;
            $display("FAIL shift[%0d]: s=%h co=%b want s=%h co=%b", i, s, co, v[i].s, v[i].co);
         end
      end
   endtask

   task automatic test_compare();
      vec_t v[7];
      v = '{
         '{5'd13, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h1, 1'b1},
         '{5'd14, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b0},
         '{5'd15, 32'h5, 32'h5, 1'b0, 32'h1, 1'b1},
         '{5'd4, 32'hF0F0, 32'h0FF0, 1'b1, 32'h00F0, 1'b0},
         '{5'd5, 32'hF0F0, 32'h0FF0, 1'b1, 32'hFFF0, 1'b0},
         '{5'd6, 32'hF0F0, 32'h0FF0, 1'b1, 32'hFF00, 1'b0},
         '{5'd7, 32'h0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0}
      };
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         f  = v[i].f;
         a  = v[i].a;
         b  = v[i].b;
         ci = v[i].ci;
         @(posedge clk);
         #1;
         total++;
         if (s !== v[i].s || co !== v[i].co) begin
            bad++;
            $display("FAIL cmp[%0d]: s=%h co=%b want s=%h co=%b", i, s, co, v[i].s, v[i].co);
         end
      end
   endtask

   task automatic test_back_to_back();
      // a=0x8000000F, b=4, ci=1; code changes every cycle, result checked right after each edge.
      logic [31:0] exp_s[32];
      logic        exp_co[32];
      exp_s = '{
         32'h8000_0014, 32'h8000_000B, 32'h8000_0010, 32'h8000_000E,
         32'h0000_0004, 32'h8000_000F, 32'h8000_000B, 32'h7FFF_FFF0,
         32'h0000_00F0, 32'h0800_0000, 32'hF800_0000, 32'h0000_00F8,
         32'hF800_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000,
         32'h8000_000F, 32'h0000_0004, 32'h0000_0000, 32'h0000_0001,
         32'h0000_0001, 32'hFFFF_FFFF, 32'h0, 32'h0,
         32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0
      };
      exp_co = '{
         1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0
      };
      @(negedge clk);
      a  = 32'h8000_000F;
      b  = 32'h4;
      ci = 1'b1;
      f  = 5'd0;
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (s !== exp_s[i] || co !== exp_co[i]) begin
            bad++;
            $display("FAIL b2b[%0d]: s=%h co=%b want s=%h co=%b", i, s, co, exp_s[i], exp_co[i]);
         end
         f = 5'(i + 1);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_add();
      test_consts();
      test_sub();
      test_shift();
      test_compare();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
